sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
- Upstream neighbour of sha256_transform. Takes a message as a stream of big-endian 32-bit words.
- Counts the message bit length and applies FIPS 180-4 padding: 0x80 marker, zero fill, then the 64-bit big-endian length.
- Emits 512-bit chunks as [15:0][31:0] on a valid/ready handshake that feeds the transform's chunk_data port directly.
- Each block is flagged as last or not-last.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Values below 64 are zero-extended into words 14/15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- msg_vld  in  1  input word valid
- msg_rdy  out  1  input word ready
- msg_data  in  32  message word; first byte in [31:24]
- msg_last  in  1  final word of the message
- msg_bytes  in  3  valid bytes in the last word, 0..4, MSB-aligned. Ignored (treated as 4) when msg_last=0.
- chunk_vld  out  1  chunk valid
- chunk_rdy  in  1  chunk ready
- chunk_data  out  16x32  chunk_data[i] is word i of the block
- chunk_last  out  1  block is the final block of the message

Behaviour:
- **Reset (rst low, async):**
  - All state clears immediately: state=FILL, ptr=0, bitlen=0, marker_done=0, buffer=0.
  - Outputs: msg_rdy=0 while rst is low; chunk_vld=0, chunk_last=0, chunk_data=0.
  - After release, msg_rdy=1 on the next cycle.
  - Reset mid-message or mid-emit discards the partial block with no output.
- **Handshakes:** a transfer occurs when vld&rdy on a rising edge. chunk_data and chunk_last are held stable while chunk_vld=1 and chunk_rdy=0. msg_rdy=1 only in FILL.
- **FILL state:** accepts one word per cycle.
  - Non-last word: buf[ptr]=msg_data; bitlen+=32; ptr+=1. If ptr was 15, go to EMIT with chunk_last=0 and pad_phase=0.
  - Last word with n=msg_bytes:
    - buf[ptr] = data bytes 0..n-1 kept, byte n = 0x80 if n<4, remaining bytes zeroed.
    - bitlen+=8n.
    - marker_done=(n<4); ptr+=1 (may reach 16).
    - Go to PAD.
  - msg_bytes>4 is illegal and is treated as 4.
- **PAD state (1 cycle):** builds the rest of the block.
  - Let p=ptr. If marker_done=0 and p<16: buf[p]=0x80000000, p+=1, marker_done=1.
  - Words p..15 are zeroed.
  - If marker_done=1 and p<=14: words 14/15 = bitlen[63:32]/bitlen[31:0], chunk_last=1.
  - Otherwise chunk_last=0.
  - Go to EMIT with pad_phase=1.
- **EMIT state:** chunk_vld=1. On handshake:
  - chunk_last=1: go to FILL; ptr=0, bitlen=0, marker_done=0.
  - pad_phase=1 and chunk_last=0: go to PAD with ptr=0 and buffer cleared. This is the second, overflow padding block.
  - pad_phase=0: go to FILL with ptr=0.
- **Latency and throughput:**
  - 16th non-last word accepted at cycle t: chunk_vld at t+1.
  - Last word accepted at cycle t: chunk_vld at t+2.
  - Minimum 1 idle input cycle per block while in EMIT.
- **Arithmetic:** bitlen wraps modulo 2^LEN_W without error.

Optional Feature:
- Macro: SHA256_PADDER_STATS_EN
- Defined: adds two outputs.
  - msg_count (out, 32): increments on every chunk handshake with chunk_last=1.
  - blk_count (out, 32): increments on every chunk handshake.
  - Both wrap at 2^32 and clear on reset.
- Not defined: the ports and counters are absent. Core behaviour is identical in both cases.

Test Plan:
- "abc": single word 0x61626300, last, bytes=3 -> one chunk: w0=0x61626380, w1..w14=0, w15=0x00000018, chunk_last=1, chunk_vld 2 cycles after accept.
- Empty message: one word, last, bytes=0 -> w0=0x80000000, w1..w15=0, chunk_last=1.
- 55-byte message (13 full words + last bytes=3) -> one block: w13=0xXXXXXX80, w15=0x000001B8, chunk_last=1.
- 56-byte message (14 full words, last bytes=4) -> two blocks:
  - block 1: w14=0x80000000, w15=0, chunk_last=0.
  - block 2: w0..w14=0, w15=0x000001C0, chunk_last=1.
- 64-byte message with chunk_rdy held low 5 cycles -> block 1 is the data with chunk_last=0 and chunk_data stable throughout the stall. Block 2: w0=0x80000000, w15=0x00000200, chunk_last=1. msg_rdy=0 during EMIT/PAD.
- rst pulsed low after 7 words of a message -> outputs clear asynchronously, no chunk is emitted. A following "abc" message produces the exact "abc" chunk above; with SHA256_PADDER_STATS_EN, msg_count=1 and blk_count=1.

Source files
------------

// File: rtl/sha256_padder_if.sv
// Message-word and padded-chunk streams between a message source and sha256_padder.
// Pure wiring, no latency.
// Both streams use valid/ready; the padder is the slave on this interface.
interface sha256_padder_if;
  logic             msg_vld;
  logic             msg_rdy;
  logic [31:0]      msg_data;
  logic             msg_last;
  logic [2:0]       msg_bytes;
  logic             chunk_vld;
  logic             chunk_rdy;
  logic [15:0][31:0] chunk_data;
  logic             chunk_last;

  modport master (
    output msg_vld, msg_data, msg_last, msg_bytes, chunk_rdy,
    input  msg_rdy, chunk_vld, chunk_data, chunk_last
  );

  modport slave (
    input  msg_vld, msg_data, msg_last, msg_bytes, chunk_rdy,
    output msg_rdy, chunk_vld, chunk_data, chunk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit chunks with marker and length.
// Latency: 16th plain word -> chunk next cycle; last word -> chunk two cycles later.
// Backpressure: msg_rdy only in FILL; chunk held stable until chunk_rdy. SHA256_PADDER_STATS_EN adds counters.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic clk,
  input  logic rst,
  sha256_padder_if.slave bus
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [31:0] msg_count,
  output logic [31:0] blk_count
`endif
);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t            state, state_n;
  logic [15:0][31:0] buffer, buffer_n;
  logic [4:0]        ptr, ptr_n;
  logic [LEN_W-1:0]  bitlen, bitlen_n;
  logic              marker_done, marker_n;
  logic              pad_phase, pad_n;
  logic              last_q, last_n;
  logic              run_q;
  logic [2:0]        nb;
  logic [31:0]       last_word;
  logic [63:0]       len64;
  logic [4:0]        p;
  logic              md;
  logic              msg_fire, chunk_fire;

  assign len64      = 64'(bitlen);
  assign msg_fire   = bus.msg_vld && bus.msg_rdy;
  assign chunk_fire = bus.chunk_vld && bus.chunk_rdy;

  // run_q keeps msg_rdy low until the first clock after reset release
  assign bus.msg_rdy    = (state == FILL) && run_q;
  assign bus.chunk_vld  = (state == EMIT);
  assign bus.chunk_data = buffer;
  assign bus.chunk_last = last_q;

  // Final word: keep the valid bytes, drop the marker right after them, zero the rest
  always_comb begin
    nb        = (bus.msg_bytes > 3'd4) ? 3'd4 : bus.msg_bytes;
    last_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nb)
        last_word[31-8*k -: 8] = bus.msg_data[31-8*k -: 8];
      else if (3'(k) == nb)
        last_word[31-8*k -: 8] = 8'h80;
    end
  end

  // Next-state and datapath updates for FILL / PAD / EMIT
  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    ptr_n    = ptr;
    bitlen_n = bitlen;
    marker_n = marker_done;
    pad_n    = pad_phase;
    last_n   = last_q;
    p        = ptr;
    md       = marker_done;
    unique case (state)
      FILL: begin
        if (msg_fire) begin
          ptr_n = ptr + 5'd1;
          if (!bus.msg_last) begin
            buffer_n[ptr[3:0]] = bus.msg_data;
            bitlen_n           = bitlen + LEN_W'(32);
            if (ptr[3:0] == 4'd15) begin
              state_n = EMIT;
              last_n  = 1'b0;
              pad_n   = 1'b0;
            end
          end else begin
            buffer_n[ptr[3:0]] = last_word;
            bitlen_n           = bitlen + LEN_W'({nb, 3'b000});
            marker_n           = (nb != 3'd4);
            state_n            = PAD;
          end
        end
      end
      PAD: begin
        // A full last word leaves the marker for the next free word, if any
        if (!md && !p[4]) begin
          buffer_n[p[3:0]] = 32'h8000_0000;
          p                = p + 5'd1;
          md               = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
          if (5'(i) >= p) buffer_n[i] = '0;
        end
        // Length only fits when words 14/15 are still free; otherwise spill a block
        if (md && (p <= 5'd14)) begin
          buffer_n[14] = len64[63:32];
          buffer_n[15] = len64[31:0];
          last_n       = 1'b1;
        end else begin
          last_n       = 1'b0;
        end
        ptr_n    = p;
        marker_n = md;
        pad_n    = 1'b1;
        state_n  = EMIT;
      end
      EMIT: begin
        if (chunk_fire) begin
          ptr_n = '0;
          if (last_q) begin
            state_n  = FILL;
            bitlen_n = '0;
            marker_n = 1'b0;
          end else if (pad_phase) begin
            state_n  = PAD;
            buffer_n = '0;
          end else begin
            state_n  = FILL;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_n;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer      <= '0;
      ptr         <= '0;
      bitlen      <= '0;
      marker_done <= 1'b0;
      pad_phase   <= 1'b0;
      last_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      buffer      <= buffer_n;
      ptr         <= ptr_n;
      bitlen      <= bitlen_n;
      marker_done <= marker_n;
      pad_phase   <= pad_n;
      last_q      <= last_n;
      run_q       <= 1'b1;
    end
  end

`ifdef SHA256_PADDER_STATS_EN
  // Message and block counters, advanced on chunk handshakes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_count <= '0;
      blk_count <= '0;
    end else if (chunk_fire) begin
      blk_count <= blk_count + 32'd1;
      if (last_q) msg_count <= msg_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: vector table of message lengths plus stall and reset sequences.
// Expected chunks come from a byte-level padding model and hand-computed words.
module tb_sha256_padder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_padder_if ifc();

`ifdef SHA256_PADDER_STATS_EN
  logic [31:0] msg_count, blk_count;
  sha256_padder #(.LEN_W(64)) dut (.clk(clk), .rst(rst), .bus(ifc),
                                   .msg_count(msg_count), .blk_count(blk_count));
`else
  sha256_padder #(.LEN_W(64)) dut (.clk(clk), .rst(rst), .bus(ifc));
`endif

  typedef struct {
    int          nbytes;
    bit          trail_empty;
    bit          bad_bytes;
    int          exp_blocks;
    logic [31:0] exp_w0;
    logic [31:0] exp_w15;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]        pb [0:191];
  logic [15:0][31:0] model [0:2];
  int                model_nblk;
  logic [15:0][31:0] first_blk, last_blk;
  logic              last_flag;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int i);
    return 8'h61 + 8'(i % 26);
  endfunction

  // Reference padding done byte-wise: data, 0x80, zeros to 56 mod 64, 64-bit length
  task automatic build_model(input int n);
    int L;
    logic [63:0] bits;
    L    = ((n + 8) / 64 + 1) * 64;
    bits = 64'(n) * 64'd8;
    for (int i = 0; i < 192; i++) pb[i] = 8'h00;
    for (int i = 0; i < n; i++) pb[i] = mbyte(i);
    pb[n] = 8'h80;
    for (int j = 0; j < 8; j++) pb[L-8+j] = bits[63-8*j -: 8];
    model_nblk = L / 64;
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < 16; w++)
        model[b][w] = {pb[64*b+4*w], pb[64*b+4*w+1], pb[64*b+4*w+2], pb[64*b+4*w+3]};
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b, output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    ifc.msg_vld   = 1'b1;
    ifc.msg_data  = d;
    ifc.msg_last  = l;
    ifc.msg_bytes = b;
    while (!ifc.msg_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = ifc.msg_rdy;
    @(posedge clk);
    #1;
    ifc.msg_vld = 1'b0;
  endtask

  task automatic send_msg(input vec_t v);
    int nw, nl, nb;
    bit last, ok;
    logic [31:0] w;
    if (v.nbytes == 0)     begin nw = 1; nl = 0; end
    else if (v.trail_empty) begin nw = v.nbytes / 4 + 1; nl = 0; end
    else begin nw = (v.nbytes + 3) / 4; nl = v.nbytes - 4 * (nw - 1); end
    for (int k = 0; k < nw; k++) begin
      last = (k == nw - 1);
      nb   = last ? nl : 4;
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (j < nb) ? mbyte(4*k+j) : 8'hA5;
      send_word(w, last, (last && v.bad_bytes) ? 3'd7 : 3'(nb), ok);
      chk("msg_accept", 512'(ok), 512'(1));
      if (last) begin
        chk("lat_pad_cycle", 512'(ifc.chunk_vld), 512'(0));
        @(posedge clk);
        #1;
        chk("lat_last_vld", 512'(ifc.chunk_vld), 512'(1));
      end else if (k % 16 == 15) begin
        chk("lat_full_vld", 512'(ifc.chunk_vld), 512'(1));
      end
    end
  endtask

  task automatic monitor(input int nexp, input int stall, output int got);
    int guard;
    logic [15:0][31:0] cap;
    logic capl;
    got = 0;
    for (int b = 0; b < nexp; b++) begin
      guard = 0;
      @(negedge clk);
      while (!ifc.chunk_vld && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (!ifc.chunk_vld) begin
        chk("chunk_timeout", 512'(0), 512'(1));
        return;
      end
      cap  = ifc.chunk_data;
      capl = ifc.chunk_last;
      chk("chunk_data", cap, model[b]);
      chk("chunk_last", 512'(capl), 512'(b == model_nblk - 1));
      chk("msg_rdy_in_emit", 512'(ifc.msg_rdy), 512'(0));
      if (b == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_vld", 512'(ifc.chunk_vld), 512'(1));
          chk("stall_data", ifc.chunk_data, cap);
          chk("stall_last", 512'(ifc.chunk_last), 512'(capl));
          chk("stall_msg_rdy", 512'(ifc.msg_rdy), 512'(0));
        end
        ifc.chunk_rdy = 1'b1;
      end
      @(posedge clk);
      if (b == 0) first_blk = cap;
      last_blk  = cap;
      last_flag = capl;
      got++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    vec_t vs;
    int got;
    bit ok;
    logic [15:0][31:0] e;

    vt[0] = '{3,   0, 0, 1, 32'h61626380, 32'h00000018};
    vt[1] = '{0,   0, 0, 1, 32'h80000000, 32'h00000000};
    vt[2] = '{55,  0, 0, 1, 32'h61626364, 32'h000001B8};
    vt[3] = '{56,  0, 0, 2, 32'h61626364, 32'h000001C0};
    vt[4] = '{64,  0, 0, 2, 32'h61626364, 32'h00000200};
    vt[5] = '{8,   1, 0, 1, 32'h61626364, 32'h00000040};
    vt[6] = '{119, 0, 0, 2, 32'h61626364, 32'h000003B8};
    vt[7] = '{12,  0, 1, 1, 32'h61626364, 32'h00000060};
    vt[8] = '{60,  0, 0, 2, 32'h61626364, 32'h000001E0};

    rst           = 1'b0;
    ifc.msg_vld   = 1'b0;
    ifc.msg_data  = '0;
    ifc.msg_last  = 1'b0;
    ifc.msg_bytes = '0;
    ifc.chunk_rdy = 1'b1;

    #22;
    chk("rst_msg_rdy", 512'(ifc.msg_rdy), 512'(0));
    chk("rst_chunk_vld", 512'(ifc.chunk_vld), 512'(0));
    chk("rst_chunk_last", 512'(ifc.chunk_last), 512'(0));
    chk("rst_chunk_data", ifc.chunk_data, 512'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_msg_rdy", 512'(ifc.msg_rdy), 512'(1));

    for (int i = 0; i < 9; i++) begin
      build_model(vt[i].nbytes);
      fork
        send_msg(vt[i]);
        monitor(vt[i].exp_blocks, 0, got);
      join
      chk($sformatf("v%0d_blocks", i), 512'(got), 512'(vt[i].exp_blocks));
      chk($sformatf("v%0d_w0", i), 512'(first_blk[0]), 512'(vt[i].exp_w0));
      chk($sformatf("v%0d_w15", i), 512'(last_blk[15]), 512'(vt[i].exp_w15));
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_no_extra", i), 512'(ifc.chunk_vld), 512'(0));
      end
    end

    // 64-byte message with the first block stalled five cycles
    vs = '{64, 0, 0, 2, 32'h61626364, 32'h00000200};
    build_model(64);
    ifc.chunk_rdy = 1'b0;
    fork
      send_msg(vs);
      monitor(2, 5, got);
    join
    ifc.chunk_rdy = 1'b1;
    chk("stall_blocks", 512'(got), 512'(2));
    chk("stall_b2_w0", 512'(last_blk[0]), 512'(32'h80000000));
    chk("stall_b2_w15", 512'(last_blk[15]), 512'(32'h00000200));
    chk("stall_b2_last", 512'(last_flag), 512'(1));

    // Reset in the middle of a message, then "abc"
    for (int k = 0; k < 7; k++) begin
      send_word({mbyte(4*k), mbyte(4*k+1), mbyte(4*k+2), mbyte(4*k+3)}, 1'b0, 3'd4, ok);
      chk("pre_rst_accept", 512'(ok), 512'(1));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_msg_rdy", 512'(ifc.msg_rdy), 512'(0));
    chk("mid_rst_chunk_vld", 512'(ifc.chunk_vld), 512'(0));
    chk("mid_rst_chunk_last", 512'(ifc.chunk_last), 512'(0));
    chk("mid_rst_chunk_data", ifc.chunk_data, 512'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_release_rdy", 512'(ifc.msg_rdy), 512'(1));
    chk("mid_rst_no_chunk", 512'(ifc.chunk_vld), 512'(0));

    build_model(3);
    fork
      begin
        send_word(32'h61626300, 1'b1, 3'd3, ok);
        chk("abc_accept", 512'(ok), 512'(1));
      end
      monitor(1, 0, got);
    join
    #1;
    e     = '0;
    e[0]  = 32'h61626380;
    e[15] = 32'h00000018;
    chk("abc_blocks", 512'(got), 512'(1));
    chk("abc_chunk", last_blk, e);
    chk("abc_last", 512'(last_flag), 512'(1));
`ifdef SHA256_PADDER_STATS_EN
    chk("stats_msg_count", 512'(msg_count), 512'(1));
    chk("stats_blk_count", 512'(blk_count), 512'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
